// File: rtl/id_stage_pipe.sv
// -----------------------------------------------------------------------------
// id_stage_pipe
//
// Decode stage of the 5-stage MIPS pipeline. It sits between the IF/ID
// register and EX. The stage contains the register file, branch/jump
// resolution, load-use and branch-operand hazard detection, forwarding into
// the branch comparator, the ID/EX pipeline register and a stall counter.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready      IF/ID -> ID handshake
//   instr, pc_plus4          instruction word and its PC+4
//   dec_*                    decoded control from the controller
//   wb_we/wb_addr/wb_data    write-back port into the register file
//   exmem_*                  EX/MEM state, used for forwarding and hazards
//   ex_ready / ex_valid      ID/EX -> EX handshake
//   flush                    squash the instruction currently in ID
//   ex_*                     registered ID/EX contents
//   branch_*, jump_*         combinational redirect to IF
//   stall, stall_cnt         hazard stall this cycle, saturating stall count
//
// Handshake: a transfer IF/ID -> ID happens on a rising edge where
// in_valid & in_ready & ~flush. A transfer ID/EX -> EX happens where
// ex_valid & ex_ready. When ex_ready is low, the ID/EX register holds every
// field. A flush also raises in_ready so that IF/ID can drop its entry.
// -----------------------------------------------------------------------------
module id_stage_pipe #(
   parameter int REG_AW    = 5,
   parameter int CTRL_W    = 15,
   parameter int WB_BYPASS = 1,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instr,
   input  logic [31:0]       pc_plus4,
   input  logic [CTRL_W-1:0] dec_ctrl,
   input  logic              dec_regwrite,
   input  logic              dec_mem_read,
   input  logic              dec_uses_rt,
   input  logic              dec_beq,
   input  logic              dec_bne,
   input  logic              dec_jump,
   input  logic [REG_AW-1:0] dec_wdst,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [31:0]       wb_data,
   input  logic              exmem_regwrite,
   input  logic              exmem_mem_read,
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic [31:0]       exmem_aluout,
   input  logic              ex_ready,
   input  logic              flush,
   output logic              ex_valid,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic              ex_regwrite,
   output logic              ex_mem_read,
   output logic [REG_AW-1:0] ex_wdst,
   output logic [REG_AW-1:0] ex_rs,
   output logic [REG_AW-1:0] ex_rt,
   output logic [REG_AW-1:0] ex_rd,
   output logic [4:0]        ex_shamt,
   output logic [31:0]       ex_rs_data,
   output logic [31:0]       ex_rt_data,
   output logic [31:0]       ex_imm,
   output logic [31:0]       ex_pc_plus4,
   output logic              branch_taken,
   output logic              jump_taken,
   output logic [31:0]       branch_target,
   output logic [31:0]       jump_target,
   output logic              stall,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int NREG = 1 << REG_AW;

   // ---------------------------------------------------------------- decode
   logic [REG_AW-1:0] rs_a, rt_a, rd_a;
   logic [31:0]       imm;

   assign rs_a = REG_AW'(instr[25:21]);
   assign rt_a = REG_AW'(instr[20:16]);
   assign rd_a = REG_AW'(instr[15:11]);
   assign imm  = {{16{instr[15]}}, instr[15:0]};

   // --------------------------------------------------------- register file
   logic [31:0] rf [NREG];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (wb_we && wb_addr != '0) begin
         rf[wb_addr] <= wb_data;
      end
   end

   logic wb_live, wb_hit_rs, wb_hit_rt;
   logic [31:0] rs_val, rt_val;

   assign wb_live   = wb_we && (wb_addr != '0);
   assign wb_hit_rs = wb_live && (wb_addr == rs_a);
   assign wb_hit_rt = wb_live && (wb_addr == rt_a);

   // Plain read ports. These feed the ID/EX operands. Entry 0 is masked so
   // that r0 still reads as zero if the array is ever written some other way.
   assign rs_val = (rs_a == '0) ? 32'h0 :
                   ((WB_BYPASS != 0) && wb_hit_rs) ? wb_data : rf[rs_a];
   assign rt_val = (rt_a == '0) ? 32'h0 :
                   ((WB_BYPASS != 0) && wb_hit_rt) ? wb_data : rf[rt_a];

   // --------------------------------------------- branch operand forwarding
   // A load in EX/MEM has no data yet, so it is excluded here. The hazard
   // logic stalls on that case instead.
   logic exm_fwd_ok;
   logic [31:0] rs_f, rt_f;

   assign exm_fwd_ok = exmem_regwrite && !exmem_mem_read && (exmem_rd != '0);

   assign rs_f = (rs_a == '0)                          ? 32'h0        :
                 (exm_fwd_ok && exmem_rd == rs_a)      ? exmem_aluout :
                 wb_hit_rs                             ? wb_data      : rf[rs_a];
   assign rt_f = (rt_a == '0)                          ? 32'h0        :
                 (exm_fwd_ok && exmem_rd == rt_a)      ? exmem_aluout :
                 wb_hit_rt                             ? wb_data      : rf[rt_a];

   // --------------------------------------------------------------- hazards
   logic load_use, br_haz, idex_prod, exm_load, is_branch, accept;

   assign load_use  = ex_valid && ex_mem_read && (ex_wdst != '0) &&
                      ((ex_wdst == rs_a) || (dec_uses_rt && ex_wdst == rt_a));
   assign idex_prod = ex_valid && ex_regwrite && (ex_wdst != '0);
   assign exm_load  = exmem_mem_read && exmem_regwrite && (exmem_rd != '0);
   assign is_branch = dec_beq || dec_bne;
   assign br_haz    = is_branch &&
                      ((idex_prod && (ex_wdst == rs_a || ex_wdst == rt_a)) ||
                       (exm_load  && (exmem_rd == rs_a || exmem_rd == rt_a)));

   assign stall    = in_valid && !flush && (load_use || br_haz);
   assign in_ready = flush || (ex_ready && !stall);
   assign accept   = in_valid && in_ready && !flush;

   // -------------------------------------------------------------- redirect
   // accept already excludes stall, flush and back-pressure, so the taken
   // flags drop to 0 in all of those cases.
   assign branch_taken  = accept && ((dec_beq && rs_f == rt_f) ||
                                     (dec_bne && rs_f != rt_f));
   assign branch_target = pc_plus4 + {imm[29:0], 2'b00};
   assign jump_taken    = accept && dec_jump;
   assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};

   // ------------------------------------------------------ ID/EX register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_valid    <= 1'b0;
         ex_ctrl     <= '0;
         ex_regwrite <= 1'b0;
         ex_mem_read <= 1'b0;
         ex_wdst     <= '0;
         ex_rs       <= '0;
         ex_rt       <= '0;
         ex_rd       <= '0;
         ex_shamt    <= '0;
         ex_rs_data  <= '0;
         ex_rt_data  <= '0;
         ex_imm      <= '0;
         ex_pc_plus4 <= '0;
      end else if (flush && ex_ready) begin
         ex_valid <= 1'b0;
      end else if (!ex_ready) begin
         // Back-pressure: hold everything, even when flush is asserted.
         ex_valid <= ex_valid;
      end else if (accept) begin
         // An all-zero word (sll r0,r0,0) is a nop, so it does not occupy EX.
         ex_valid    <= (instr != 32'h0);
         ex_ctrl     <= dec_ctrl;
         ex_regwrite <= dec_regwrite;
         ex_mem_read <= dec_mem_read;
         ex_wdst     <= dec_wdst;
         ex_rs       <= rs_a;
         ex_rt       <= rt_a;
         ex_rd       <= rd_a;
         ex_shamt    <= instr[10:6];
         ex_rs_data  <= rs_val;
         ex_rt_data  <= rt_val;
         ex_imm      <= imm;
         ex_pc_plus4 <= pc_plus4;
      end else begin
         // Bubble. The data fields keep their old contents and are don't-care.
         ex_valid <= 1'b0;
      end
   end

   // ------------------------------------------------------ stall counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_id_stage_pipe.sv
// -----------------------------------------------------------------------------
// tb_id_stage_pipe
//
// Directed bench for id_stage_pipe. Inputs change 1 time unit after a rising
// edge. Combinational outputs are checked 1 time unit later. Registered
// outputs are checked 1 time unit after the following edge.
// -----------------------------------------------------------------------------
module tb_id_stage_pipe;

   localparam int REG_AW = 5;
   localparam int CTRL_W = 15;
   localparam int CNT_W  = 16;

   // ---------------------------------------------------- clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic              in_valid, in_ready;
   logic [31:0]       instr, pc_plus4;
   logic [CTRL_W-1:0] dec_ctrl;
   logic              dec_regwrite, dec_mem_read, dec_uses_rt;
   logic              dec_beq, dec_bne, dec_jump;
   logic [REG_AW-1:0] dec_wdst;
   logic              wb_we;
   logic [REG_AW-1:0] wb_addr;
   logic [31:0]       wb_data;
   logic              exmem_regwrite, exmem_mem_read;
   logic [REG_AW-1:0] exmem_rd;
   logic [31:0]       exmem_aluout;
   logic              ex_ready, flush;
   logic              ex_valid;
   logic [CTRL_W-1:0] ex_ctrl;
   logic              ex_regwrite, ex_mem_read;
   logic [REG_AW-1:0] ex_wdst, ex_rs, ex_rt, ex_rd;
   logic [4:0]        ex_shamt;
   logic [31:0]       ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus4;
   logic              branch_taken, jump_taken;
   logic [31:0]       branch_target, jump_target;
   logic              stall;
   logic [CNT_W-1:0]  stall_cnt;

   id_stage_pipe #(
      .REG_AW(REG_AW), .CTRL_W(CTRL_W), .WB_BYPASS(1), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .pc_plus4(pc_plus4), .dec_ctrl(dec_ctrl),
      .dec_regwrite(dec_regwrite), .dec_mem_read(dec_mem_read),
      .dec_uses_rt(dec_uses_rt), .dec_beq(dec_beq), .dec_bne(dec_bne),
      .dec_jump(dec_jump), .dec_wdst(dec_wdst),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .exmem_regwrite(exmem_regwrite), .exmem_mem_read(exmem_mem_read),
      .exmem_rd(exmem_rd), .exmem_aluout(exmem_aluout),
      .ex_ready(ex_ready), .flush(flush),
      .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
      .ex_regwrite(ex_regwrite), .ex_mem_read(ex_mem_read),
      .ex_wdst(ex_wdst), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_shamt(ex_shamt), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
      .ex_imm(ex_imm), .ex_pc_plus4(ex_pc_plus4),
      .branch_taken(branch_taken), .jump_taken(jump_taken),
      .branch_target(branch_target), .jump_target(jump_target),
      .stall(stall), .stall_cnt(stall_cnt)
   );

   // ------------------------------------------------------ scoreboard
   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------- driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; instr = '0; pc_plus4 = '0; dec_ctrl = '0;
      dec_regwrite = 1'b0; dec_mem_read = 1'b0; dec_uses_rt = 1'b0;
      dec_beq = 1'b0; dec_bne = 1'b0; dec_jump = 1'b0; dec_wdst = '0;
      wb_we = 1'b0; wb_addr = '0; wb_data = '0;
      exmem_regwrite = 1'b0; exmem_mem_read = 1'b0; exmem_rd = '0;
      exmem_aluout = '0; ex_ready = 1'b1; flush = 1'b0;
   endtask

   // Present an instruction with all decode flags cleared. The caller sets
   // the flags it needs afterwards.
   task automatic present(input logic [31:0] iw, input logic [31:0] pc);
      in_valid = 1'b1; instr = iw; pc_plus4 = pc; dec_ctrl = iw[14:0];
      dec_regwrite = 1'b0; dec_mem_read = 1'b0; dec_uses_rt = 1'b0;
      dec_beq = 1'b0; dec_bne = 1'b0; dec_jump = 1'b0; dec_wdst = '0;
   endtask

   // ------------------------------------------------------- stimulus
   initial begin
      logic [31:0] j_word;
      j_word = {6'h02, 26'h0000040};

      // Reset then idle
      rst = 1'b0;
      idle_inputs();
      step(); step();
      check("rst_ex_valid", 32'(ex_valid), 32'h0);
      check("rst_stall_cnt", 32'(stall_cnt), 32'h0);
      rst = 1'b1;
      step();
      check("idle_ex_valid", 32'(ex_valid), 32'h0);

      // A write to r0 must be ignored.
      wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD;
      step();
      wb_we = 1'b0;
      present({6'h0, 5'd0, 5'd0, 5'd1, 5'd0, 6'h20}, 32'h4);
      step();
      check("r0_read", ex_rs_data, 32'h0);
      check("r0_valid", 32'(ex_valid), 32'h1);

      // r1..r31 read zero after reset.
      for (int i = 1; i < 32; i++) begin
         present({6'h0, 5'(i), 5'(i), 5'd1, 5'd0, 6'h20}, 32'h8);
         exp_q.push_back(32'h0);
         step();
         check($sformatf("rf_clear_r%0d", i), ex_rs_data, exp_q.pop_front());
      end

      // A same-cycle write-back is seen by the read ports.
      wb_we = 1'b1; wb_addr = 5'd10; wb_data = 32'h0000_1234;
      present({6'h0, 5'd10, 5'd10, 5'd1, 5'd0, 6'h20}, 32'hC);
      step();
      wb_we = 1'b0;
      check("bypass_rs", ex_rs_data, 32'h0000_1234);
      check("bypass_rt", ex_rt_data, 32'h0000_1234);

      // An all-zero instruction loads as not valid.
      present(32'h0, 32'h10);
      step();
      check("nop_invalid", 32'(ex_valid), 32'h0);

      // Load-use: lw r8 then add r9,r8,r8.
      present({6'h23, 5'd1, 5'd8, 16'h0000}, 32'h20);
      dec_regwrite = 1'b1; dec_mem_read = 1'b1; dec_wdst = 5'd8;
      #1;
      check("lw_in_ready", 32'(in_ready), 32'h1);
      step();
      check("lw_ex_mem_read", 32'(ex_mem_read), 32'h1);
      present({6'h0, 5'd8, 5'd8, 5'd9, 5'd0, 6'h20}, 32'h24);
      dec_regwrite = 1'b1; dec_uses_rt = 1'b1; dec_wdst = 5'd9;
      #1;
      check("lu_stall", 32'(stall), 32'h1);
      check("lu_in_ready", 32'(in_ready), 32'h0);
      step();
      check("lu_bubble", 32'(ex_valid), 32'h0);
      check("lu_stall_cnt", 32'(stall_cnt), 32'h1);
      check("lu_stall_clear", 32'(stall), 32'h0);
      step();
      check("lu_add_valid", 32'(ex_valid), 32'h1);
      check("lu_add_wdst", 32'(ex_wdst), 32'd9);
      check("lu_stall_cnt2", 32'(stall_cnt), 32'h1);

      // Branch forwarding: r5 comes from EX/MEM and r6 comes from WB, both 7.
      exmem_regwrite = 1'b1; exmem_mem_read = 1'b0; exmem_rd = 5'd5;
      exmem_aluout = 32'h7;
      wb_we = 1'b1; wb_addr = 5'd6; wb_data = 32'h7;
      present({6'h04, 5'd5, 5'd6, 16'hFFFF}, 32'h100);
      dec_beq = 1'b1;
      #1;
      check("beq_fwd_taken", 32'(branch_taken), 32'h1);
      check("beq_fwd_target", branch_target, 32'h0000_00FC);
      check("beq_fwd_stall", 32'(stall), 32'h0);
      step();
      present({6'h05, 5'd5, 5'd6, 16'hFFFF}, 32'h100);
      dec_bne = 1'b1;
      #1;
      check("bne_fwd_not_taken", 32'(branch_taken), 32'h0);
      step();
      // Without forwarding, r5 is still 0 in the file and r6 is now 7.
      exmem_regwrite = 1'b0; wb_we = 1'b0;
      present({6'h05, 5'd5, 5'd6, 16'h0001}, 32'h104);
      dec_bne = 1'b1;
      #1;
      check("bne_rf_taken", 32'(branch_taken), 32'h1);
      check("bne_rf_target", branch_target, 32'h0000_0108);
      step();

      // Branch whose operand is produced by the instruction in ID/EX.
      present({6'h0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'h1FC);
      dec_regwrite = 1'b1; dec_uses_rt = 1'b1; dec_wdst = 5'd3;
      step();
      present({6'h04, 5'd3, 5'd0, 16'h0002}, 32'h200);
      dec_beq = 1'b1;
      #1;
      check("br_idex_stall", 32'(stall), 32'h1);
      check("br_idex_no_redirect", 32'(branch_taken), 32'h0);
      step();
      check("br_idex_bubble", 32'(ex_valid), 32'h0);
      check("br_idex_stall_cnt", 32'(stall_cnt), 32'h2);
      // The add has moved to EX/MEM with result 0.
      exmem_regwrite = 1'b1; exmem_rd = 5'd3; exmem_aluout = 32'h0;
      #1;
      check("br_idex_resolved_stall", 32'(stall), 32'h0);
      check("br_idex_taken", 32'(branch_taken), 32'h1);
      check("br_idex_target", branch_target, 32'h0000_0208);
      step();
      exmem_regwrite = 1'b0; exmem_rd = '0;

      // Back-pressure: addi-like instruction in ID/EX, then a jump held in ID.
      present({6'h08, 5'd1, 5'd2, 16'h0042}, 32'h300);
      dec_regwrite = 1'b1; dec_wdst = 5'd2;
      step();
      check("bp_pre_pc", ex_pc_plus4, 32'h300);
      check("bp_pre_imm", ex_imm, 32'h42);
      present(j_word, 32'h4000_0010);
      dec_jump = 1'b1;
      ex_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("bp_in_ready_%0d", k), 32'(in_ready), 32'h0);
         check($sformatf("bp_no_jump_%0d", k), 32'(jump_taken), 32'h0);
         step();
         check($sformatf("bp_hold_pc_%0d", k), ex_pc_plus4, 32'h300);
         check($sformatf("bp_hold_valid_%0d", k), 32'(ex_valid), 32'h1);
      end
      ex_ready = 1'b1;
      #1;
      check("bp_release_in_ready", 32'(in_ready), 32'h1);
      check("bp_release_jump", 32'(jump_taken), 32'h1);
      check("j_target", jump_target, 32'h4000_0100);
      step();
      check("bp_accept_pc", ex_pc_plus4, 32'h4000_0010);
      check("bp_accept_valid", 32'(ex_valid), 32'h1);

      // Flush a jump in ID, then present it again without the flush.
      present(j_word, 32'h4000_0010);
      dec_jump = 1'b1;
      flush = 1'b1;
      #1;
      check("flush_no_jump", 32'(jump_taken), 32'h0);
      check("flush_in_ready", 32'(in_ready), 32'h1);
      step();
      check("flush_ex_valid", 32'(ex_valid), 32'h0);
      flush = 1'b0;
      #1;
      check("unflushed_jump", 32'(jump_taken), 32'h1);
      check("unflushed_target", jump_target, 32'h4000_0100);
      step();
      check("unflushed_valid", 32'(ex_valid), 32'h1);

      idle_inputs();
      step();
      check("final_stall_cnt", 32'(stall_cnt), 32'h2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
